peripheral_dsa_modular_exponentiator_initiator: RTL and testbench

//  Initiator side of the modular-multiplier START/READY protocol: computes BASE^EXPONENT mod MODULO
//  by issuing a sequence of multiply and square requests to an external modular multiplier.

---
 rtl/peripheral_dsa_pkg.sv | 17 +
 rtl/peripheral_dsa_timeout_counter.sv | 41 ++++
 rtl/peripheral_dsa_modular_exponentiator_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_peripheral_dsa_modular_exponentiator_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_dsa_pkg.sv
// Shared types and sizing for the peripheral_dsa modular-arithmetic blocks.
package peripheral_dsa_pkg;

  localparam int unsigned DATA_SIZE              = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL_ISSUE,
    MUL_WAIT,
    SQR_ISSUE,
    SQR_WAIT,
    DONE
  } exp_state_t;

endpackage : peripheral_dsa_pkg

// File: rtl/peripheral_dsa_timeout_counter.sv
// Saturating wait-cycle counter; expired_c flags the LIMIT-th consecutive enabled cycle.
module peripheral_dsa_timeout_counter
  import peripheral_dsa_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // This enabled cycle is the one that brings the count to LIMIT.
  assign expired_c = enable && (count_q >= CNT_LAST);

endmodule : peripheral_dsa_timeout_counter

// File: rtl/peripheral_dsa_modular_exponentiator_initiator.sv
// Right-to-left square-and-multiply sequencer driving an external modular multiplier
// over its START/READY handshake; computes BASE^EXPONENT mod MODULO.
module peripheral_dsa_modular_exponentiator_initiator #(
  parameter int unsigned DATA_SIZE      = peripheral_dsa_pkg::DATA_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = peripheral_dsa_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] MODULO,
  input  logic [DATA_SIZE-1:0] DATA_BASE_IN,
  input  logic [DATA_SIZE-1:0] DATA_EXP_IN,
  output logic                 READY,
  output logic                 BUSY,
  output logic                 ERROR,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 MUL_START,
  output logic [DATA_SIZE-1:0] MUL_MODULO,
  output logic [DATA_SIZE-1:0] MUL_DATA_A_IN,
  output logic [DATA_SIZE-1:0] MUL_DATA_B_IN,
  input  logic                 MUL_READY,
  input  logic [DATA_SIZE-1:0] MUL_DATA_OUT
);

  import peripheral_dsa_pkg::*;

  exp_state_t state_q, state_d;

  logic [DATA_SIZE-1:0] acc_q, acc_d;
  logic [DATA_SIZE-1:0] base_q, base_d;
  logic [DATA_SIZE-1:0] exp_q, exp_d;
  logic [DATA_SIZE-1:0] mod_q, mod_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic [DATA_SIZE-1:0] mul_a_q, mul_a_d;
  logic [DATA_SIZE-1:0] mul_b_q, mul_b_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic                 mul_start_q, mul_start_d;

  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired_c;

  peripheral_dsa_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST),
    .clear     (tmr_clear),
    .enable    (tmr_enable),
    .expired_c (tmr_expired_c)
  );

  // Sequencer: every transition into DONE also loads READY/ERROR/DATA_OUT so
  // READY coincides with the DONE cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    base_d      = base_q;
    exp_d       = exp_q;
    mod_d       = mod_q;
    data_out_d  = data_out_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    ready_d     = 1'b0;
    busy_d      = busy_q;
    error_d     = error_q;
    mul_start_d = 1'b0;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          mod_d   = MODULO;
          base_d  = DATA_BASE_IN;
          exp_d   = DATA_EXP_IN;
          acc_d   = (MODULO == DATA_SIZE'(1)) ? '0 : DATA_SIZE'(1);
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (mod_q == '0) begin
          state_d    = DONE;
          ready_d    = 1'b1;
          error_d    = 1'b1;
          data_out_d = '0;
        end else if (exp_q == '0) begin
          state_d    = DONE;
          ready_d    = 1'b1;
          error_d    = 1'b0;
          data_out_d = acc_q;
        end else if (exp_q[0]) begin
          state_d = MUL_ISSUE;
        end else begin
          state_d = SQR_ISSUE;
        end
      end

      MUL_ISSUE: begin
        mul_start_d = 1'b1;
        mul_a_d     = acc_q;
        mul_b_d     = base_q;
        tmr_clear   = 1'b1;
        state_d     = MUL_WAIT;
      end

      MUL_WAIT: begin
        tmr_enable = 1'b1;
        if (MUL_READY) begin
          acc_d = MUL_DATA_OUT;
          // Last set bit consumed: the trailing square would be wasted work.
          if ((exp_q >> 1) == '0) begin
            state_d    = DONE;
            ready_d    = 1'b1;
            error_d    = 1'b0;
            data_out_d = MUL_DATA_OUT;
          end else begin
            state_d = SQR_ISSUE;
          end
        end else if (tmr_expired_c) begin
          state_d    = DONE;
          ready_d    = 1'b1;
          error_d    = 1'b1;
          data_out_d = '0;
        end
      end

      SQR_ISSUE: begin
        mul_start_d = 1'b1;
        mul_a_d     = base_q;
        mul_b_d     = base_q;
        tmr_clear   = 1'b1;
        state_d     = SQR_WAIT;
      end

      SQR_WAIT: begin
        tmr_enable = 1'b1;
        if (MUL_READY) begin
          base_d  = MUL_DATA_OUT;
          exp_d   = exp_q >> 1;
          state_d = CHECK;
        end else if (tmr_expired_c) begin
          state_d    = DONE;
          ready_d    = 1'b1;
          error_d    = 1'b1;
          data_out_d = '0;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      base_q      <= '0;
      exp_q       <= '0;
      mod_q       <= '0;
      data_out_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      mod_q       <= mod_d;
      data_out_q  <= data_out_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      mul_start_q <= mul_start_d;
    end
  end

  assign READY         = ready_q;
  assign BUSY          = busy_q;
  assign ERROR         = error_q;
  assign DATA_OUT      = data_out_q;
  assign MUL_START     = mul_start_q;
  assign MUL_MODULO    = mod_q;
  assign MUL_DATA_A_IN = mul_a_q;
  assign MUL_DATA_B_IN = mul_b_q;

endmodule : peripheral_dsa_modular_exponentiator_initiator

// File: tb/tb_peripheral_dsa_modular_exponentiator_initiator.sv
// Bench for the modular exponentiator initiator with a behavioural multiplier responder
// and a scoreboard fed by a plain-arithmetic modpow model.
module tb_peripheral_dsa_modular_exponentiator_initiator;

  import peripheral_dsa_pkg::*;

  localparam int unsigned W   = DATA_SIZE;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] modulo = '0;
  logic [W-1:0] base_in = '0;
  logic [W-1:0] exp_in = '0;
  logic         ready;
  logic         busy;
  logic         error;
  logic [W-1:0] data_out;
  logic         mul_start;
  logic [W-1:0] mul_modulo;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         mul_ready;
  logic [W-1:0] mul_data_out;

  peripheral_dsa_modular_exponentiator_initiator #(
    .DATA_SIZE      (W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK           (clk),
    .RST           (rst_n),
    .START         (start),
    .MODULO        (modulo),
    .DATA_BASE_IN  (base_in),
    .DATA_EXP_IN   (exp_in),
    .READY         (ready),
    .BUSY          (busy),
    .ERROR         (error),
    .DATA_OUT      (data_out),
    .MUL_START     (mul_start),
    .MUL_MODULO    (mul_modulo),
    .MUL_DATA_A_IN (mul_a),
    .MUL_DATA_B_IN (mul_b),
    .MUL_READY     (mul_ready),
    .MUL_DATA_OUT  (mul_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: textbook modular exponentiation and call count.
  function automatic longint unsigned model_pow(input longint unsigned b, input longint unsigned e,
                                                input longint unsigned m);
    longint unsigned r;
    if (m == 0) return 0;
    r = 1 % m;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int model_calls(input longint unsigned e);
    int k = 0;
    int p = 0;
    if (e == 0) return 0;
    while (e > 0) begin
      k++;
      if (e[0]) p++;
      e = e >> 1;
    end
    return p + k - 1;
  endfunction

  typedef struct {
    longint unsigned m;
    longint unsigned data;
    bit              err;
    int              calls;
  } exp_rec_t;

  exp_rec_t sb_q[$];

  int lm          = 1;
  bit resp_mute   = 1'b0;
  int resp_active = 0;
  int total_starts = 0;
  int ready_cnt   = 0;
  int last_ms_cyc = 0;
  int start_cyc   = 0;

  // Multiplier responder: answers each MUL_START after lm cycles, watching operands meanwhile.
  logic [W-1:0] ra, rb, rm;
  bit aborted;
  initial begin : responder
    mul_ready    = 1'b0;
    mul_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (mul_start && rst_n && !resp_mute) begin
        ra = mul_a; rb = mul_b; rm = mul_modulo;
        aborted = 1'b0;
        resp_active = 1;
        for (int i = 1; i < lm; i++) begin
          @(posedge clk); #1;
          if (!rst_n) aborted = 1'b1;
          if (!aborted) begin
            check("operand A stable", mul_a, ra);
            check("operand B stable", mul_b, rb);
            check("single MUL_START", mul_start, 0);
          end
        end
        mul_data_out = (rm == '0) ? '0 : W'((64'(ra) * 64'(rb)) % 64'(rm));
        mul_ready = 1'b1;
        @(posedge clk); #1;
        mul_ready = 1'b0;
        resp_active = 0;
      end
    end
  end

  // Scoreboard compare on every falling edge.
  int mul_cnt = 0;
  logic [W-1:0] last_data = '0;
  always @(negedge clk) begin : cmp
    exp_rec_t e;
    if (!rst_n) begin
      sb_q.delete();
      mul_cnt   = 0;
      last_data = '0;
      check("reset READY", ready, 0);
      check("reset BUSY", busy, 0);
      check("reset ERROR", error, 0);
      check("reset DATA_OUT", data_out, 0);
      check("reset MUL_START", mul_start, 0);
      check("reset MUL_MODULO", mul_modulo, 0);
    end else begin
      if (mul_start) begin
        mul_cnt++;
        total_starts++;
        last_ms_cyc = cyc;
      end
      if (busy && sb_q.size() > 0) check("MUL_MODULO held", mul_modulo, sb_q[0].m);
      if (ready) begin
        ready_cnt++;
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected READY: got data %0d with none pending (cycle %0d)", data_out, cyc);
        end else begin
          e = sb_q.pop_front();
          check("scoreboard DATA_OUT", data_out, e.data);
          check("scoreboard ERROR", error, e.err);
          check("scoreboard call count", mul_cnt, e.calls);
          last_data = W'(e.data);
        end
        mul_cnt = 0;
      end else begin
        check("DATA_OUT hold", data_out, last_data);
      end
    end
  end

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] b, input logic [W-1:0] e,
                       input bit push, input bit tmo);
    exp_rec_t r;
    @(posedge clk); #1;
    modulo = m; base_in = b; exp_in = e; start = 1'b1;
    start_cyc = cyc;
    if (push) begin
      r.m     = m;
      r.data  = tmo ? 0 : model_pow(b, e, m);
      r.err   = tmo || (m == 0);
      r.calls = tmo ? 1 : ((m == 0) ? 0 : model_calls(e));
      sb_q.push_back(r);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int rc);
    bit seen = 1'b0;
    rc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        rc = cyc;
        break;
      end
    end
    check({tag, " READY seen"}, seen, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rc;
    int s0;
    int r0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model against hand-worked values.
    check("model 3^5 mod 7", model_pow(3, 5, 7), 5);
    check("model 4^13 mod 497", model_pow(4, 13, 497), 445);
    check("model 9^0 mod 11", model_pow(9, 0, 11), 1);
    check("model calls exp=5", model_calls(5), 4);
    check("model calls exp=13", model_calls(13), 6);

    // 1: small case, four multiplier calls
    lm = 3;
    s0 = total_starts;
    issue(7, 3, 5, 1, 0);
    wait_ready("t1", rc);
    check("t1 DATA_OUT", data_out, 5);
    check("t1 ERROR", error, 0);
    check("t1 MUL_START count", total_starts - s0, 4);

    // 2: larger exponent, and zero exponent
    lm = 8;
    issue(497, 4, 13, 1, 0);
    wait_ready("t2a", rc);
    check("t2a DATA_OUT", data_out, 445);
    lm = 1;
    s0 = total_starts;
    issue(11, 9, 0, 1, 0);
    wait_ready("t2b", rc);
    check("t2b DATA_OUT", data_out, 1);
    check("t2b MUL_START count", total_starts - s0, 0);

    // 3: unit modulus, zero modulus
    lm = 2;
    issue(1, 0, 3, 1, 0);
    wait_ready("t3a", rc);
    check("t3a DATA_OUT", data_out, 0);
    check("t3a ERROR", error, 0);
    issue(0, 5, 3, 1, 0);
    wait_ready("t3b", rc);
    check("t3b READY latency", rc - start_cyc, 2);
    check("t3b ERROR", error, 1);
    check("t3b DATA_OUT", data_out, 0);
    check("t3b BUSY on READY", busy, 1);
    @(negedge clk);
    check("t3b BUSY after READY", busy, 0);

    // 4: silent multiplier -> timeout
    resp_mute = 1'b1;
    issue(7, 3, 1, 1, 1);
    wait_ready("t4", rc);
    check("t4 timeout latency", rc - last_ms_cyc, TMO);
    check("t4 ERROR", error, 1);
    check("t4 DATA_OUT", data_out, 0);
    @(negedge clk);
    check("t4 BUSY after READY", busy, 0);
    resp_mute = 1'b0;

    // 5: second START while busy is dropped
    lm = 4;
    r0 = ready_cnt;
    issue(497, 4, 13, 1, 0);
    issue(7, 3, 5, 0, 0);
    wait_ready("t5", rc);
    check("t5 DATA_OUT", data_out, 445);
    repeat (60) @(negedge clk);
    check("t5 READY pulses", ready_cnt - r0, 1);

    // 6: reset mid-wait, late MUL_READY, then a clean request
    lm = 6;
    issue(7, 3, 5, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mul_start) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    r0 = ready_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_active == 0) break;
    end
    repeat (4) @(negedge clk);
    check("t6 no READY after reset", ready_cnt - r0, 0);
    check("t6 BUSY idle", busy, 0);
    check("t6 DATA_OUT cleared", data_out, 0);
    lm = 2;
    issue(7, 3, 5, 1, 0);
    wait_ready("t6", rc);
    check("t6 DATA_OUT", data_out, 5);
    check("t6 ERROR", error, 0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_peripheral_dsa_modular_exponentiator_initiator
